alu_frame_ctrl: RTL
===================

ALU_FRAME_CTRL -- requirements
Module: alu_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, meaning operand/result width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter TRAMA_SIZE, default 8, meaning UART frame width in bits; fixed at 8.
REQ-003 SHALL have parameter OPCODE_SIZE, default 6, meaning opcode width in bits; legal values are 1 to 8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of idle clocks allowed between bytes of one command.
REQ-005 SHALL define NBYTES = DATA_SIZE/8 internally.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_rx_done_tick, input, 1 bit: one-cycle strobe meaning i_rx_data is valid.
REQ-009 SHALL have port i_rx_data, input, TRAMA_SIZE bits: the received byte.
REQ-010 SHALL have port i_res, input, DATA_SIZE bits: the combinational ALU result.
REQ-011 SHALL have port i_tx_done_tick, input, 1 bit: one-cycle strobe meaning the UART transmitter has finished a byte.
REQ-012 SHALL have port o_a, output, DATA_SIZE bits: operand A to the ALU.
REQ-013 SHALL have port o_b, output, DATA_SIZE bits: operand B to the ALU.
REQ-014 SHALL have port o_opcode, output, OPCODE_SIZE bits: opcode to the ALU.
REQ-015 SHALL have port o_tx_data, output, TRAMA_SIZE bits: the byte to transmit.
REQ-016 SHALL have port o_tx_start, output, 1 bit: one-cycle transmit request.
REQ-017 SHALL have port o_busy, output, 1 bit: high in every state except RX_A with 0 bytes received.
REQ-018 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a command is aborted by timeout.
REQ-019 SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a byte arrives while the block is not accepting bytes.

Function
REQ-020 SHALL implement states RX_A, RX_B, RX_OP, EXEC, TX_LOAD and TX_WAIT, with a byte index counter of width clog2(NBYTES+1).
REQ-021 SHALL accept a command frame of A (NBYTES bytes, LSB first), then B (NBYTES bytes, LSB first), then one opcode byte, whose low OPCODE_SIZE bits are used.
REQ-022 SHALL, in RX_A and RX_B, write each byte into byte lane [index] of o_a or o_b, increment the index, and on the last byte clear the index and advance to RX_B or RX_OP respectively.
REQ-023 SHALL, in RX_OP, load o_opcode on i_rx_done_tick and go to EXEC.
REQ-024 SHALL, in EXEC (one cycle), capture i_res into an internal result register and go to TX_LOAD.
REQ-025 SHALL, in TX_LOAD, drive o_tx_data with result byte [index] (LSB first), pulse o_tx_start for exactly one cycle, and go to TX_WAIT.
REQ-026 SHALL, in TX_WAIT, on i_tx_done_tick, increment the index and return to TX_LOAD if bytes remain, otherwise clear the index and return to RX_A.
REQ-027 SHALL ignore i_tx_done_tick outside TX_WAIT.
REQ-028 SHALL fix latency from the opcode byte strobe to the first o_tx_start at exactly 2 cycles (EXEC, then TX_LOAD).
REQ-029 SHALL hold o_a, o_b and o_opcode stable from the end of reception until overwritten by the next command; partial overwrite of o_a and o_b during reception is permitted.
REQ-030 SHALL treat a byte strobe in EXEC, TX_LOAD or TX_WAIT as follows: drop the byte, pulse o_overrun, and leave state unchanged.
REQ-031 SHALL run the timeout counter only in RX_A with index > 0, in RX_B and in RX_OP; the counter clears on every accepted byte and on every state change.
REQ-032 SHALL, when the timeout counter reaches TIMEOUT_CYCLES-1 without a strobe, go to RX_A, clear the index, and pulse o_timeout; o_a, o_b and o_opcode keep their values.
REQ-033 SHALL, when a byte strobe coincides with timeout expiry, accept the byte and not fire the timeout.
REQ-034 SHALL never stall or reorder bytes; every byte strobe is either consumed or flagged as overrun.

Reset
REQ-035 SHALL, on i_reset low at any time, including mid-frame or mid-transmit, immediately enter RX_A with index 0 and timeout counter 0.
REQ-036 SHALL, while in reset, hold o_a, o_b, o_opcode, o_tx_data and the result register at 0, and hold o_tx_start, o_busy, o_timeout and o_overrun at 0.
REQ-037 SHALL resume normal operation on the first rising edge of i_clk after i_reset goes high.

Verification (DATA_SIZE=16, TIMEOUT_CYCLES=50, ALU model with ADD = 0x20)
REQ-038 SHALL cover: bytes 34,12,01,00,20 -> o_a=0x1234, o_b=0x0001, o_opcode=0x20; o_tx_start 2 cycles after the last strobe with data 0x35; after tx_done, second start with 0x12; then o_busy=0.
REQ-039 SHALL cover: bytes 34,12 then 50 idle cycles -> o_timeout pulse exactly at cycle 49; next bytes are parsed as a new A.
REQ-040 SHALL cover: a byte strobe during TX_WAIT -> o_overrun pulse; the transmitted bytes and their count are unchanged.
REQ-041 SHALL cover: i_reset asserted after 3 bytes and after the first o_tx_start -> all outputs 0; a following full frame completes correctly.
REQ-042 SHALL cover: a strobe on the same cycle as timeout expiry -> byte accepted and no o_timeout pulse.
REQ-043 SHALL cover: i_tx_done_tick in RX_A -> no state change and no o_tx_start.

Source files
------------

// File: rtl/alu_frame_ctrl.sv
// UART-to-ALU framing controller: collects operand A, operand B and an opcode byte,
// lets the external ALU compute for one cycle, then streams the result back LSB first.
module alu_frame_ctrl #(
    parameter int unsigned DATA_SIZE      = 16,
    parameter int unsigned TRAMA_SIZE     = 8,
    parameter int unsigned OPCODE_SIZE    = 6,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rx_done_tick,
    input  logic [TRAMA_SIZE-1:0]  i_rx_data,
    input  logic [DATA_SIZE-1:0]   i_res,
    input  logic                   i_tx_done_tick,
    output logic [DATA_SIZE-1:0]   o_a,
    output logic [DATA_SIZE-1:0]   o_b,
    output logic [OPCODE_SIZE-1:0] o_opcode,
    output logic [TRAMA_SIZE-1:0]  o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_timeout,
    output logic                   o_overrun
);

    localparam int unsigned NBYTES = DATA_SIZE / 8;
    localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StRxA, StRxB, StRxOp, StExec, StTxLoad, StTxWait
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [DATA_SIZE-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OPCODE_SIZE-1:0] op_q, op_d;
    logic                   accept, overrun, tmo_run, tmo_fire;
    logic [7:0]             tx_byte;

    // State, byte index, timeout counter and data registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StRxA;
            idx_q   <= '0;
            tmo_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    // Next-state, byte-lane writes, overrun detection and inter-byte timeout
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        res_d    = res_q;
        accept   = 1'b0;
        overrun  = 1'b0;
        tmo_fire = 1'b0;
        // Counter only runs once a command is partially received
        tmo_run  = (state_q == StRxA && idx_q != '0) || state_q == StRxB || state_q == StRxOp;

        unique case (state_q)
            StRxA, StRxB: begin
                if (i_rx_done_tick) begin
                    accept = 1'b1;
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            if (state_q == StRxA) a_d[i*8 +: 8] = i_rx_data[7:0];
                            else                  b_d[i*8 +: 8] = i_rx_data[7:0];
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (state_q == StRxA) ? StRxB : StRxOp;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StRxOp: begin
                if (i_rx_done_tick) begin
                    accept  = 1'b1;
                    op_d    = i_rx_data[OPCODE_SIZE-1:0];
                    state_d = StExec;
                end
            end
            StExec: begin
                overrun = i_rx_done_tick;
                res_d   = i_res;
                state_d = StTxLoad;
            end
            StTxLoad: begin
                overrun = i_rx_done_tick;
                state_d = StTxWait;
            end
            StTxWait: begin
                overrun = i_rx_done_tick;
                if (i_tx_done_tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StRxA;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StTxLoad;
                    end
                end
            end
            default: begin
                state_d = StRxA;
                idx_d   = '0;
            end
        endcase

        // A strobe on the expiry cycle wins over the timeout
        if (tmo_run && !i_rx_done_tick && tmo_q == TMO_LAST) begin
            tmo_fire = 1'b1;
            state_d  = StRxA;
            idx_d    = '0;
        end

        if (!tmo_run || accept || tmo_fire || state_d != state_q) tmo_d = '0;
        else                                                      tmo_d = tmo_q + TMO_W'(1);
    end

    // Result byte selected by the byte index
    always_comb begin
        tx_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) tx_byte = res_q[i*8 +: 8];
        end
    end

    assign o_a        = a_q;
    assign o_b        = b_q;
    assign o_opcode   = op_q;
    assign o_tx_data  = tx_byte;
    assign o_tx_start = (state_q == StTxLoad);
    assign o_busy     = !(state_q == StRxA && idx_q == '0);
    assign o_timeout  = tmo_fire;
    assign o_overrun  = overrun;

endmodule
